// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Fetch sequencer for the 32-bit CPU. It steps pc_reg through BOOT, FETCH and
// ISSUE. It requests instruction words at the current PC and hands them to
// decode over a valid/ready handshake. It also picks the next PC: sequential
// +4, a taken branch target, or the trap vector.
//
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   PC              current PC read back from pc_reg
//   PC_EN, PC_NEXT  load enable / next value driven to pc_reg
//   IMEM_REQ/ADDR   instruction memory request and address (address = PC)
//   IMEM_ACK/RDATA  memory response; RDATA is valid in the ACK cycle
//   INSTR/VALID     instruction to decode and its valid flag
//   INSTR_READY     decode accepts INSTR
//   BR_TAKEN/TARGET branch redirect, only looked at in the handshake cycle
//   TRAP            trap request level, looked at every cycle
//   MISALIGN_ERR    one-cycle pulse after a misaligned taken branch target
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC,
    output logic        PC_EN,
    output logic [31:0] PC_NEXT,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_ACK,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    input  logic        INSTR_READY,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    input  logic        TRAP,
    output logic        MISALIGN_ERR
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t      state;
    logic        trap_pend;
    logic [31:0] pc_plus4;
    logic        fetch_redirect;
    logic        handshake;
    logic        br_misaligned;

    // PC+4 wraps naturally in 32 bits; the carry is simply dropped.
    assign pc_plus4       = PC + 32'd4;
    // The request cannot be cancelled, so a trap seen during FETCH only takes
    // effect when the outstanding request is acknowledged.
    assign fetch_redirect = (state == FETCH) && IMEM_ACK && (trap_pend || TRAP);
    assign handshake      = (state == ISSUE) && INSTR_VALID && INSTR_READY;
    assign br_misaligned  = BR_TAKEN && (BR_TARGET[1:0] != 2'b00);

    // The request is a pure decode of the state register, so an asynchronous
    // reset removes it immediately without waiting for a clock edge.
    assign IMEM_REQ  = (state == FETCH);
    assign IMEM_ADDR = PC;

    // pc_reg load control. It must act in the same cycle as the ACK or the
    // handshake, so it is combinational. Trap has the highest priority, then
    // the branch target.
    always_comb begin
        PC_EN   = 1'b0;
        PC_NEXT = pc_plus4;
        case (state)
            BOOT: begin
                PC_EN   = 1'b1;
                PC_NEXT = RESET_VEC;
            end
            FETCH: begin
                if (fetch_redirect) begin
                    PC_EN   = 1'b1;
                    PC_NEXT = TRAP_VEC;
                end
            end
            ISSUE: begin
                if (TRAP) begin
                    PC_EN   = 1'b1;
                    PC_NEXT = TRAP_VEC;
                end else if (handshake) begin
                    PC_EN = 1'b1;
                    if (BR_TAKEN && !br_misaligned) begin
                        PC_NEXT = BR_TARGET;
                    end else if (BR_TAKEN) begin
                        PC_NEXT = TRAP_VEC;
                    end else begin
                        PC_NEXT = pc_plus4;
                    end
                end
            end
            default: begin
                PC_EN   = 1'b0;
                PC_NEXT = pc_plus4;
            end
        endcase
    end

    // State register and registered outputs. MISALIGN_ERR defaults low every
    // cycle, so a misaligned handshake produces exactly a one-cycle pulse.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= BOOT;
            INSTR        <= 32'h0000_0000;
            INSTR_VALID  <= 1'b0;
            MISALIGN_ERR <= 1'b0;
            trap_pend    <= 1'b0;
        end else begin
            MISALIGN_ERR <= 1'b0;
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (IMEM_ACK) begin
                        trap_pend <= 1'b0;
                        if (!(trap_pend || TRAP)) begin
                            INSTR       <= IMEM_RDATA;
                            INSTR_VALID <= 1'b1;
                            state       <= ISSUE;
                        end
                    end else if (TRAP) begin
                        trap_pend <= 1'b1;
                    end
                end
                ISSUE: begin
                    // A trap squashes the held instruction whether decode
                    // is ready or not.
                    if (TRAP) begin
                        INSTR_VALID <= 1'b0;
                        state       <= FETCH;
                    end else if (handshake) begin
                        INSTR_VALID  <= 1'b0;
                        MISALIGN_ERR <= br_misaligned;
                        state        <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl. It contains a small pc_reg model and a
// memory whose data is a fixed function of the address. Expected fetch
// addresses and expected instruction words go into scoreboard queues when
// the stimulus is driven. They are popped when the DUT issues the matching
// request or handshake.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_taken;
    logic [31:0] br_target;
    logic        trap;
    logic        misalign_err;

    logic [31:0] addr_q[$];
    logic [31:0] instr_q[$];
    logic        exp_mis;
    int          errors;
    int          checks;

    fetch_ctrl #(
        .RESET_VEC(RESET_VEC),
        .TRAP_VEC (TRAP_VEC)
    ) dut (
        .CLK         (clk),
        .RST_N       (rst_n),
        .PC          (pc),
        .PC_EN       (pc_en),
        .PC_NEXT     (pc_next),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_ACK    (imem_ack),
        .IMEM_RDATA  (imem_rdata),
        .INSTR       (instr),
        .INSTR_VALID (instr_valid),
        .INSTR_READY (instr_ready),
        .BR_TAKEN    (br_taken),
        .BR_TARGET   (br_target),
        .TRAP        (trap),
        .MISALIGN_ERR(misalign_err)
    );

    // Free-running clock with a 10-unit period.
    always #5 clk = ~clk;

    // pc_reg model. It resets to a junk value, so only the BOOT load can
    // bring it to the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 32'h0BAD_0000;
        end else if (pc_en) begin
            pc <= pc_next;
        end
    end

    // Memory contents derived from the address, so every word is distinct.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Drives one cycle of inputs just after the falling edge. It then lets
    // the combinational outputs settle before anything is sampled.
    task automatic applyStimulus(input logic ack, input logic [31:0] rdata,
                                 input logic ready, input logic br,
                                 input logic [31:0] tgt, input logic trp);
        @(negedge clk);
        imem_ack    = ack;
        imem_rdata  = rdata;
        instr_ready = ready;
        br_taken    = br;
        br_target   = tgt;
        trap        = trp;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The misalignment pulse is expected only in the first cycle after the
    // handshake that caused it.
    task automatic checkMisalign();
        checkOutput("misalign_err", {31'd0, misalign_err}, {31'd0, exp_mis});
        exp_mis = 1'b0;
    endtask

    task automatic releaseAndBoot();
        @(negedge clk);
        rst_n       = 1'b1;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        trap        = 1'b0;
        #1;
        checkOutput("boot_pc_en", {31'd0, pc_en}, 32'd1);
        checkOutput("boot_pc_next", pc_next, RESET_VEC);
        checkOutput("boot_req", {31'd0, imem_req}, 32'd0);
        addr_q.push_back(RESET_VEC);
    endtask

    // One instruction: wait ack_wait cycles for the ACK, then stall ready_wait
    // cycles in ISSUE, then end with a handshake (or a squash).
    task automatic run_instr(input int ack_wait, input int rdy_wait,
                             input logic br, input logic [31:0] tgt,
                             input logic trap_hs, input logic squash);
        logic [31:0] addr;
        logic [31:0] nxt;
        logic [31:0] got;
        logic [1:0]  low;
        logic        mis;
        addr = addr_q.pop_front();
        for (int i = 0; i <= ack_wait; i++) begin
            applyStimulus(i == ack_wait,
                          (i == ack_wait) ? memWord(addr) : 32'hBAD0_0000 + i,
                          1'b0, 1'b0, 32'h0, 1'b0);
            checkOutput("imem_req", {31'd0, imem_req}, 32'd1);
            checkOutput("imem_addr", imem_addr, addr);
            checkOutput("pc_en_fetch", {31'd0, pc_en}, 32'd0);
            checkOutput("valid_fetch", {31'd0, instr_valid}, 32'd0);
            checkMisalign();
        end
        instr_q.push_back(memWord(addr));
        // Stray ACKs and branch requests while stalled must be ignored.
        for (int i = 0; i < rdy_wait; i++) begin
            applyStimulus(1'b1, 32'hFACE_0000 | i, 1'b0, 1'b1, 32'h0000_0002, 1'b0);
            checkOutput("valid_stall", {31'd0, instr_valid}, 32'd1);
            checkOutput("instr_stall", instr, instr_q[0]);
            checkOutput("req_stall", {31'd0, imem_req}, 32'd0);
            checkOutput("pc_en_stall", {31'd0, pc_en}, 32'd0);
            checkMisalign();
        end
        mis = 1'b0;
        low = tgt[1:0];
        if (squash || trap_hs) begin
            nxt = TRAP_VEC;
        end else if (br && low == 2'b00) begin
            nxt = tgt;
        end else if (br) begin
            nxt = TRAP_VEC;
            mis = 1'b1;
        end else begin
            nxt = addr + 32'd4;
        end
        applyStimulus(1'b0, 32'h0, !squash, br, tgt, trap_hs || squash);
        got = instr_q.pop_front();
        checkOutput("instr_hs", instr, got);
        checkOutput("valid_hs", {31'd0, instr_valid}, 32'd1);
        checkOutput("req_hs", {31'd0, imem_req}, 32'd0);
        checkOutput("pc_en_hs", {31'd0, pc_en}, 32'd1);
        checkOutput("pc_next_hs", pc_next, nxt);
        checkMisalign();
        addr_q.push_back(nxt);
        exp_mis = mis;
    endtask

    // A fetch hit by a trap pulse: the request stays up until the ACK, then
    // the word is dropped and the PC is redirected to the trap vector.
    task automatic run_trap_fetch(input int ack_wait, input int trap_cycle);
        logic [31:0] addr;
        addr = addr_q.pop_front();
        for (int i = 0; i <= ack_wait; i++) begin
            applyStimulus(i == ack_wait, memWord(addr), 1'b0, 1'b0, 32'h0,
                          i == trap_cycle);
            checkOutput("trap_req", {31'd0, imem_req}, 32'd1);
            checkOutput("trap_addr", imem_addr, addr);
            checkOutput("trap_valid", {31'd0, instr_valid}, 32'd0);
            checkOutput("trap_pc_en", {31'd0, pc_en}, {31'd0, i == ack_wait});
            if (i == ack_wait) begin
                checkOutput("trap_pc_next", pc_next, TRAP_VEC);
            end
            checkMisalign();
        end
        addr_q.push_back(TRAP_VEC);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        exp_mis     = 1'b0;
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        br_taken    = 1'b0;
        br_target   = 32'h0;
        trap        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("rst_mis", {31'd0, misalign_err}, 32'd0);
        checkOutput("rst_instr", instr, 32'd0);

        // Back-to-back fetches at 0, 4, 8, 12.
        releaseAndBoot();
        for (int k = 0; k < 4; k++) begin
            run_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Slow memory and a stalled decode at 0x10, then plain steps to 0x20.
        run_instr(3, 2, 1'b0, 32'h0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_instr(1, 1, 1'b0, 32'h0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

        // At 0x20 an aligned branch, then a misaligned one at 0x1000.
        run_instr(0, 0, 1'b1, 32'h0000_1000, 1'b0, 1'b0);
        run_instr(0, 0, 1'b1, 32'h0000_1002, 1'b0, 1'b0);

        // Branch to the top of memory; the sequential step wraps to 0.
        run_instr(0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0);
        run_instr(0, 1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Trap pulse in FETCH cycle 1 with ACK in cycle 3.
        run_trap_fetch(2, 0);
        // Trap and taken branch together: the trap vector wins.
        run_instr(0, 0, 1'b1, 32'h0000_2000, 1'b1, 1'b0);
        // Trap while decode is stalled squashes the instruction.
        run_instr(0, 2, 1'b0, 32'h0, 1'b0, 1'b1);

        // Misaligned branch, then reset in the middle of the next FETCH.
        run_instr(0, 0, 1'b1, 32'h0000_0443, 1'b0, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("pre_rst_req", {31'd0, imem_req}, 32'd1);
        checkMisalign();
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_req", {31'd0, imem_req}, 32'd0);
        checkOutput("async_rst_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("async_rst_mis", {31'd0, misalign_err}, 32'd0);
        checkOutput("async_rst_instr", instr, 32'd0);
        addr_q.delete();
        instr_q.delete();
        exp_mis = 1'b0;
        @(negedge clk);
        releaseAndBoot();
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
        run_instr(0, 0, 1'b0, 32'h0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
